lfsr_fibonacci_checker: RTL and testbench
=========================================

Name: lfsr_fibonacci_checker

Overview:
- Serial PRBS checker sitting directly downstream of the 16-bit Fibonacci LFSR generator; consumes the generator's one-bit-per-clock output stream.
- Self-synchronises to the generator's polynomial, then flywheels, counts bit errors, and drops lock on burst errors.
- Used on loopback paths and in self-test to validate serial links driven by the generator.

Parameters:
- LOCK_CNT, 32: consecutive correct predictions needed after seeding before lock is declared (1..255).
- WIN_LEN, 64: length in accepted bits of the loss-of-lock error window (2..255).
- ERR_THRESH, 8: errors within one window that force loss of lock (1..WIN_LEN).
- CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit is accepted on this rising edge.
- in_bit  input  1  serial bit from the generator (its lfsr_out).
- clr_cnt  input  1  synchronous clear of err_cnt.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle pulse for each mismatched bit while locked.
- err_cnt  output  CNT_W  saturating count of mismatches while locked.

Behaviour:
- Reset (nrst low, asynchronous): state=SEED, 16-bit history=0, all counters=0, locked=0, err_pulse=0, err_cnt=0. Reset mid-stream discards all progress.
- Cycles with in_valid=0 leave all state unchanged. err_pulse is 0 on those cycles.
- History h: h[k] is the bit accepted k+1 valid cycles ago. Prediction p = h[15]^h[1]^h[2]. This matches s(n)=s(n-16)^s(n-2)^s(n-3), the generator's output recurrence.
- SEED:
  - Shift in_bit into h and count accepted bits.
  - After the 16th bit, go to VERIFY if the new history is nonzero.
  - If the new history is all-zero, restart the 16-bit count and stay in SEED. An all-zero stream never locks.
- VERIFY:
  - Shift in_bit into h.
  - If in_bit==p, increment the match count. When it reaches LOCK_CNT, go to LOCKED; locked=1 from the following cycle.
  - If in_bit!=p, clear the match count and go to SEED with a fresh 16-bit count. The offending bit is retained in h.
  - err_cnt is not touched in this state.
- LOCKED (flywheel):
  - Shift p, not in_bit, into h, so a single corrupted bit yields exactly one error.
  - On mismatch: err_pulse=1 on the next cycle (registered, 1-cycle latency), and err_cnt increments, saturating at 2^CNT_W-1.
  - Window: a bit counter runs 0..WIN_LEN-1 alongside a window error count. When the window completes without tripping, both clear.
  - If the window error count reaches ERR_THRESH, go to SEED and deassert locked on the next cycle. err_cnt keeps its value.
- clr_cnt has priority over the increment, but a mismatch in the same cycle is still counted: err_cnt becomes 1. clr_cnt does not affect state or lock.
- A mismatch on the same cycle that trips the threshold is counted and pulsed; the transition to SEED happens in that same cycle.

Optional Feature:
- Macro LFSR_CHK_BITCNT_EN.
- Defined: adds output bit_cnt (32 bits), counting in_valid bits accepted while locked. It wraps modulo 2^32, clears on clr_cnt or reset, and holds when not locked. This gives a BER denominator.
- Undefined: no bit_cnt port and no counter logic. Everything else is identical.

Test Plan:
- Generator init 16'hA2C1 drives in_bit with in_valid=1 every cycle, defaults used -> locked rises the cycle after the 48th accepted bit; err_cnt=0 and no err_pulse over 10000 bits.
- After lock, invert one bit -> exactly one err_pulse, err_cnt=1, locked stays 1.
- After lock, set err_cnt near saturation (CNT_W=4, 20 isolated single-bit errors) -> err_cnt stops at 15. Then assert clr_cnt on the same cycle as the next error -> err_cnt=1.
- After lock, replace the stream with random bits -> locked falls within 64 bits. Restore the generator stream -> relock 48 bits later.
- in_bit stuck at 0 for 1000 bits -> locked stays 0 and state never leaves SEED. Random in_valid gaps (about 50%) on a good stream -> same lock point counted in accepted bits, with no errors.
- Assert nrst low for 1 cycle mid-lock -> locked=0 and err_cnt=0 immediately. With LFSR_CHK_BITCNT_EN defined, bit_cnt=0 on reset and equals (accepted bits - 48) after relock.

Source files
------------

// File: rtl/lfsr_fibonacci_checker.sv
// Serial PRBS checker for the 16-bit Fibonacci generator s(n)=s(n-16)^s(n-2)^s(n-3).
// Optional macro LFSR_CHK_BITCNT_EN adds a 32-bit bit_cnt of bits accepted while locked.
module lfsr_fibonacci_checker #(
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
`ifdef LFSR_CHK_BITCNT_EN
  output logic [31:0]      bit_cnt,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned HIST_W = 16;
  localparam int unsigned SEED_W = 4;
  localparam int unsigned CTR_W  = 8;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [HIST_W-1:0]   hist, hist_d, hist_shift;
  logic [SEED_W-1:0]   seed_cnt, seed_cnt_d;
  logic [CTR_W-1:0]    match_cnt, match_cnt_d, match_inc;
  logic [CTR_W-1:0]    win_bits, win_bits_d;
  logic [CTR_W-1:0]    win_errs, win_errs_d, win_errs_inc;
  logic [CNT_W-1:0]    err_cnt_d;
  logic                err_pulse_d;
  logic                locked_d;
  logic                pred;
  logic                mism;
`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0]         bit_cnt_d;
`endif

  assign pred         = hist[15] ^ hist[1] ^ hist[2];
  assign mism         = in_bit ^ pred;
  assign hist_shift   = {hist[HIST_W-2:0], in_bit};
  assign match_inc    = match_cnt + CTR_W'(1);
  assign win_errs_inc = win_errs + CTR_W'(mism);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    hist_d      = hist;
    seed_cnt_d  = seed_cnt;
    match_cnt_d = match_cnt;
    win_bits_d  = win_bits;
    win_errs_d  = win_errs;
    err_pulse_d = 1'b0;
    err_cnt_d   = clr_cnt ? '0 : err_cnt;

    if (in_valid) begin
      unique case (state)
        ST_SEED: begin
          hist_d = hist_shift;
          if (seed_cnt == SEED_W'(15)) begin
            seed_cnt_d = '0;
            if (hist_shift != '0) begin
              state_d     = ST_VERIFY;
              match_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt + SEED_W'(1);
          end
        end

        ST_VERIFY: begin
          hist_d = hist_shift;
          if (!mism) begin
            if (match_inc == CTR_W'(LOCK_CNT)) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
              win_bits_d  = '0;
              win_errs_d  = '0;
            end else begin
              match_cnt_d = match_inc;
            end
          end else begin
            state_d     = ST_SEED;
            match_cnt_d = '0;
            seed_cnt_d  = '0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: feed back the prediction so one bad bit costs one error
          hist_d = {hist[HIST_W-2:0], pred};
          if (mism) begin
            err_pulse_d = 1'b1;
            if (err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
          end
          if (win_errs_inc == CTR_W'(ERR_THRESH)) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits == CTR_W'(WIN_LEN - 1)) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits + CTR_W'(1);
            win_errs_d = win_errs_inc;
          end
        end

        default: state_d = ST_SEED;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);

`ifdef LFSR_CHK_BITCNT_EN
    if (clr_cnt)                              bit_cnt_d = '0;
    else if (in_valid && state == ST_LOCKED)  bit_cnt_d = bit_cnt + 32'd1;
    else                                      bit_cnt_d = bit_cnt;
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_SEED;
      hist      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
`ifdef LFSR_CHK_BITCNT_EN
      bit_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      hist      <= hist_d;
      seed_cnt  <= seed_cnt_d;
      match_cnt <= match_cnt_d;
      win_bits  <= win_bits_d;
      win_errs  <= win_errs_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_cnt   <= err_cnt_d;
`ifdef LFSR_CHK_BITCNT_EN
      bit_cnt   <= bit_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_lfsr_fibonacci_checker.sv
// Randomised bench for lfsr_fibonacci_checker: a default instance and a CNT_W=4 instance
// share one stimulus and are compared every cycle against a queue-based behavioural model.
module tb_lfsr_fibonacci_checker;

  localparam int unsigned LOCK_CNT   = 32;
  localparam int unsigned WIN_LEN    = 64;
  localparam int unsigned ERR_THRESH = 8;
  localparam logic [15:0] GEN_INIT   = 16'hA2C1;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_bit;
  logic        clr_cnt;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] err_a;
  logic [3:0]  err_b;
`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0] bitcnt_a, bitcnt_b;
`endif

  always #5 clk = ~clk;

  lfsr_fibonacci_checker dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked_a), .err_pulse(pulse_a),
`ifdef LFSR_CHK_BITCNT_EN
    .bit_cnt(bitcnt_a),
`endif
    .err_cnt(err_a)
  );

  lfsr_fibonacci_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked_b), .err_pulse(pulse_b),
`ifdef LFSR_CHK_BITCNT_EN
    .bit_cnt(bitcnt_b),
`endif
    .err_cnt(err_b)
  );

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: modes 0=seeding, 1=verifying, 2=locked; hq holds last 16 history bits, oldest first
  int          m_mode, m_seedn, m_match, m_winb, m_wine;
  int          m_err_a, m_err_b;
  bit          m_pulse, m_locked;
  logic [31:0] m_bitcnt;
  bit          hq[$];

  task automatic model_reset();
    hq.delete();
    repeat (16) hq.push_back(1'b0);
    m_mode = 0; m_seedn = 0; m_match = 0; m_winb = 0; m_wine = 0;
    m_err_a = 0; m_err_b = 0; m_pulse = 0; m_locked = 0; m_bitcnt = '0;
  endtask

  task automatic hist_push(input bit b);
    hq.push_back(b);
    void'(hq.pop_front());
  endtask

  task automatic model_update(input bit v, input bit b, input bit c);
    bit p, nz;
    if (c) begin m_err_a = 0; m_err_b = 0; m_bitcnt = '0; end
    m_pulse = 0;
    if (v) begin
      p = hq[0] ^ hq[13] ^ hq[14];
      if (m_mode == 0) begin
        hist_push(b);
        m_seedn++;
        if (m_seedn == 16) begin
          m_seedn = 0;
          nz = 0;
          foreach (hq[i]) nz |= hq[i];
          if (nz) begin m_mode = 1; m_match = 0; end
        end
      end else if (m_mode == 1) begin
        hist_push(b);
        if (b == p) begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_mode = 2; m_match = 0; m_winb = 0; m_wine = 0; end
        end else begin
          m_match = 0; m_seedn = 0; m_mode = 0;
        end
      end else begin
        if (!c) m_bitcnt = m_bitcnt + 32'd1;
        hist_push(p);
        if (b != p) begin
          m_pulse = 1;
          m_err_a = (m_err_a < 65535) ? m_err_a + 1 : 65535;
          m_err_b = (m_err_b < 15) ? m_err_b + 1 : 15;
          m_wine++;
        end
        if (m_wine >= ERR_THRESH) begin
          m_mode = 0; m_seedn = 0; m_winb = 0; m_wine = 0;
        end else if (m_winb == WIN_LEN - 1) begin
          m_winb = 0; m_wine = 0;
        end else begin
          m_winb++;
        end
      end
    end
    m_locked = (m_mode == 2);
  endtask

  // Reference generator: first the 16 seed bits, then the recurrence
  bit gq[$];
  int gen_n;
  logic [15:0] gen_seed;

  task automatic gen_reset(input logic [15:0] s);
    gq.delete(); gen_n = 0; gen_seed = s;
  endtask

  task automatic gen_next(output bit b);
    if (gen_n < 16) b = gen_seed[15 - gen_n];
    else            b = gq[0] ^ gq[13] ^ gq[14];
    gen_n++;
    gq.push_back(b);
    if (gq.size() > 16) void'(gq.pop_front());
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    @(negedge clk);
    #1;
    in_valid = v; in_bit = b; clr_cnt = c;
    @(posedge clk);
    model_update(v, b, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    in_valid = 0; clr_cnt = 0; nrst = 0;
    model_reset();
    #1;
    chk("rst_locked", 64'(locked_a), 64'd0);
    chk("rst_err_cnt", 64'(err_a), 64'd0);
    chk("rst_err_cnt4", 64'(err_b), 64'd0);
`ifdef LFSR_CHK_BITCNT_EN
    chk("rst_bit_cnt", 64'(bitcnt_a), 64'd0);
`endif
    @(negedge clk);
    #1;
    nrst = 1;
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("locked", 64'(locked_a), 64'(m_locked));
      chk("err_pulse", 64'(pulse_a), 64'(m_pulse));
      chk("err_cnt", 64'(err_a), 64'(m_err_a));
      chk("locked4", 64'(locked_b), 64'(m_locked));
      chk("err_pulse4", 64'(pulse_b), 64'(m_pulse));
      chk("err_cnt4", 64'(err_b), 64'(m_err_b));
`ifdef LFSR_CHK_BITCNT_EN
      chk("bit_cnt", 64'(bitcnt_a), 64'(m_bitcnt));
      chk("bit_cnt4", 64'(bitcnt_b), 64'(m_bitcnt));
`endif
    end
  end

  initial begin
    bit g;
    int lock_at, npulse, drop_at, relock_at, nlock, acc, lock_acc;
    nrst = 0; in_valid = 0; in_bit = 0; clr_cnt = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk("init_locked", 64'(locked_a), 64'd0);
    chk("init_err_pulse", 64'(pulse_a), 64'd0);
    chk("init_err_cnt", 64'(err_a), 64'd0);
    nrst = 1;
    check_en = 1;

    // Clean generator stream: lock after 48 bits, no errors
    gen_reset(GEN_INIT);
    lock_at = 0; npulse = 0;
    for (int i = 1; i <= 10000; i++) begin
      gen_next(g);
      step(1, g, 0);
      #1;
      if (locked_a && lock_at == 0) lock_at = i;
      if (pulse_a) npulse++;
    end
    chk("lock_point", 64'(lock_at), 64'd48);
    chk("clean_err_cnt", 64'(err_a), 64'd0);
    chk("clean_pulses", 64'(npulse), 64'd0);

    // Single inverted bit
    npulse = 0;
    gen_next(g);
    step(1, ~g, 0);
    #1;
    if (pulse_a) npulse++;
    for (int i = 0; i < 5; i++) begin
      gen_next(g);
      step(1, g, 0);
      #1;
      if (pulse_a) npulse++;
    end
    chk("single_pulses", 64'(npulse), 64'd1);
    chk("single_err_cnt", 64'(err_a), 64'd1);
    chk("single_locked", 64'(locked_a), 64'd1);

    // Isolated errors drive the 4-bit counter into saturation
    for (int e = 0; e < 20; e++) begin
      gen_next(g);
      step(1, ~g, 0);
      for (int i = 0; i < 11; i++) begin
        gen_next(g);
        step(1, g, 0);
      end
    end
    #1;
    chk("sat_err_cnt4", 64'(err_b), 64'd15);
    chk("sat_err_cnt16", 64'(err_a), 64'd21);
    chk("sat_locked", 64'(locked_b), 64'd1);
    gen_next(g);
    step(1, ~g, 1);
    #1;
    chk("clr_with_err4", 64'(err_b), 64'd1);
    chk("clr_with_err16", 64'(err_a), 64'd1);

    // Random bits break lock; the restored stream relocks
    drop_at = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1, 1'($urandom_range(1, 0)), 0);
      #1;
      if (!locked_a && drop_at == 0) drop_at = i;
    end
    chk("drop_within_window", 64'(drop_at != 0 && drop_at <= 64), 64'd1);
    relock_at = 0;
    for (int i = 1; i <= 200; i++) begin
      gen_next(g);
      step(1, g, 0);
      #1;
      if (locked_a && relock_at == 0) relock_at = i;
    end
    chk("relock_bound", 64'(relock_at >= 48 && relock_at <= 150), 64'd1);

    // Stuck-at-zero stream never locks
    do_reset();
    nlock = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1, 0, 0);
      #1;
      if (locked_a) nlock++;
    end
    chk("stuck0_locked_cycles", 64'(nlock), 64'd0);

    // Gapped valid: lock point counted in accepted bits
    do_reset();
    gen_reset(GEN_INIT);
    acc = 0; lock_acc = 0;
    for (int i = 0; i < 600; i++) begin
      bit v;
      v = 1'($urandom_range(1, 0));
      if (v) gen_next(g);
      else   g = 1'($urandom_range(1, 0));
      step(v, g, 0);
      if (v) acc++;
      #1;
      if (locked_a && lock_acc == 0) lock_acc = acc;
    end
    chk("gap_lock_point", 64'(lock_acc), 64'd48);
    chk("gap_err_cnt", 64'(err_a), 64'd0);
`ifdef LFSR_CHK_BITCNT_EN
    chk("gap_bit_cnt", 64'(bitcnt_a), 64'(acc - 48));
`endif

    // Errors then reset mid-lock; relock from scratch
    for (int e = 0; e < 2; e++) begin
      gen_next(g);
      step(1, ~g, 0);
      gen_next(g);
      step(1, g, 0);
    end
    do_reset();
    gen_reset(GEN_INIT);
    for (int i = 0; i < 80; i++) begin
      gen_next(g);
      step(1, g, 0);
    end
    #1;
    chk("post_rst_locked", 64'(locked_a), 64'd1);
`ifdef LFSR_CHK_BITCNT_EN
    chk("post_rst_bit_cnt", 64'(bitcnt_a), 64'd32);
`endif

    @(negedge clk);
    #1;
    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
